// File: rtl/multi_counter_regif.sv
// multi_counter_regif: NUM_CH independent up/down counters behind one
// word-addressed register bus.
//
// Ports
//   clk       : single clock, all state updates on posedge
//   rst       : synchronous, active-high reset
//   wr_en     : write strobe (one register write per cycle)
//   rd_en     : read strobe
//   addr      : byte address, word aligned (ADDR_WIDTH >= 9)
//   wdata     : write data
//   rdata     : combinational read data, 0 when idle or unmapped
//   overflow  : per-channel terminal pulse, combinational
//   irq       : OR of (sticky & mask), registered
//
// Register map: channel n at n*0x10 (CTRL +0, VALUE +4, LIMIT +8, STATUS +C),
// IRQ_MASK at 0x100.
//
// Build option: MCNT_STATUS_IRQ_EN enables the STATUS sticky bits, IRQ_MASK
// and irq. Without it those registers are unmapped and irq is tied low.

module multi_counter_regif #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic [NUM_CH-1:0]     overflow,
  output logic                  irq
);

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CTRL_W    = 4;
  localparam int unsigned CH_IDX_W  = 4;
  localparam int unsigned START_B   = 0;
  localparam int unsigned CLR_B     = 1;
  localparam int unsigned DIR_B     = 2;
  localparam int unsigned ONESHOT_B = 3;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_VALUE  = 2'd1;
  localparam logic [1:0] REG_LIMIT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] GLB_ADDR = ADDR_WIDTH'(32'h100);

  logic [CTRL_W-1:0]    ctrl_q  [NUM_CH];
  logic [CTRL_W-1:0]    ctrl_d  [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_q   [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_d   [NUM_CH];
  logic [CNT_WIDTH-1:0] limit_q [NUM_CH];
  logic [CNT_WIDTH-1:0] limit_d [NUM_CH];

  logic [NUM_CH-1:0]   counting;
  logic [NUM_CH-1:0]   terminal;
  logic [NUM_CH-1:0]   wrap;
  logic [NUM_CH-1:0]   wr_ch;
  logic [CH_IDX_W-1:0] ch_sel;
  logic [1:0]          reg_sel;
  logic                ch_hit;
  logic                glb_hit;

`ifdef MCNT_STATUS_IRQ_EN
  logic [NUM_CH-1:0] sticky_q;
  logic [NUM_CH-1:0] sticky_d;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] mask_d;
  logic              irq_q;
  logic              irq_d;
`endif

  // Low address bits and upper wdata bits are don't-care by design.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata};

  // Address decode: channel window below 0x100, single global word at 0x100.
  always_comb begin
    ch_sel  = addr[7:4];
    reg_sel = addr[3:2];
    ch_hit  = (addr[ADDR_WIDTH-1:8] == '0) && ({1'b0, ch_sel} < 5'(NUM_CH));
    glb_hit = (addr[ADDR_WIDTH-1:2] == GLB_ADDR[ADDR_WIDTH-1:2]);
  end

  // Terminal detection and the combinational overflow pulse.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      counting[i] = ctrl_q[i][START_B] & ~ctrl_q[i][CLR_B];
      terminal[i] = ctrl_q[i][DIR_B] ? (cnt_q[i] == '0) : (cnt_q[i] >= limit_q[i]);
      wrap[i]     = counting[i] & terminal[i];
      wr_ch[i]    = wr_en & ch_hit & (ch_sel == CH_IDX_W'(i));
    end
    overflow = wrap;
  end

  // Next-state for counters, control and limit registers.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ctrl_d[i]  = ctrl_q[i];
      cnt_d[i]   = cnt_q[i];
      limit_d[i] = limit_q[i];

      if (ctrl_q[i][CLR_B]) begin
        cnt_d[i] = '0;
      end else if (counting[i]) begin
        if (terminal[i]) cnt_d[i] = ctrl_q[i][DIR_B] ? limit_q[i] : '0;
        else if (ctrl_q[i][DIR_B]) cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
        else cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end

      // One-shot auto-stop; a same-cycle CPU write to CTRL takes precedence.
      if (wrap[i] && ctrl_q[i][ONESHOT_B]) ctrl_d[i][START_B] = 1'b0;
      if (wr_ch[i] && (reg_sel == REG_CTRL)) ctrl_d[i] = wdata[CTRL_W-1:0];
      if (wr_ch[i] && (reg_sel == REG_LIMIT)) limit_d[i] = wdata[CNT_WIDTH-1:0];
    end
  end

`ifdef MCNT_STATUS_IRQ_EN
  // Sticky status: hardware set wins over a simultaneous W1C.
  always_comb begin
    sticky_d = sticky_q;
    mask_d   = mask_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_ch[i] && (reg_sel == REG_STATUS) && wdata[0]) sticky_d[i] = 1'b0;
      if (wrap[i]) sticky_d[i] = 1'b1;
    end
    if (wr_en && glb_hit) mask_d = wdata[NUM_CH-1:0];
    irq_d = |(sticky_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
      mask_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      mask_q   <= mask_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Per-channel register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ctrl_q[i]  <= '0;
        cnt_q[i]   <= '0;
        limit_q[i] <= '1;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        ctrl_q[i]  <= ctrl_d[i];
        cnt_q[i]   <= cnt_d[i];
        limit_q[i] <= limit_d[i];
      end
    end
  end

  // Zero-latency read mux.
  always_comb begin
    rdata = '0;
    if (rd_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_hit && (ch_sel == CH_IDX_W'(i))) begin
          case (reg_sel)
            REG_CTRL:   rdata = DATA_W'(ctrl_q[i]);
            REG_VALUE:  rdata = DATA_W'(cnt_q[i]);
            REG_LIMIT:  rdata = DATA_W'(limit_q[i]);
`ifdef MCNT_STATUS_IRQ_EN
            REG_STATUS: rdata = DATA_W'(sticky_q[i]);
`endif
            default:    rdata = '0;
          endcase
        end
      end
`ifdef MCNT_STATUS_IRQ_EN
      if (glb_hit) rdata = DATA_W'(mask_q);
`endif
    end
  end

endmodule

// File: tb/tb_multi_counter_regif.sv
// Directed bench for multi_counter_regif (NUM_CH=4, CNT_WIDTH=8).
// Expectations follow MCNT_STATUS_IRQ_EN when it is defined for the build.
`timescale 1ns/1ps

module tb_multi_counter_regif;

`ifdef MCNT_STATUS_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  overflow;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_up[6] = '{1, 2, 3, 4, 0, 1};
  int exp_dn[6] = '{0, 3, 2, 1, 0, 3};
  int exp_os[3] = '{1, 2, 0};

  multi_counter_regif #(.NUM_CH(4), .CNT_WIDTH(8), .ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .overflow(overflow), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Register write lands on the next posedge.
  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input logic [9:0] a, input logic [31:0] exp, input string tag);
    addr = a; rd_en = 1'b1;
    #1;
    chk(rdata, exp, tag);
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
    tick(3);
    rst = 1'b0;

    // 1: reset state
    for (int c = 0; c < 4; c++) begin
      chk_rd(10'(c * 16 + 0),  32'h0,  "rst_ctrl");
      chk_rd(10'(c * 16 + 4),  32'h0,  "rst_value");
      chk_rd(10'(c * 16 + 8),  32'hFF, "rst_limit");
      chk_rd(10'(c * 16 + 12), 32'h0,  "rst_status");
    end
    chk_rd(10'h100, 32'h0, "rst_mask");
    chk(32'(irq), 32'h0, "rst_irq");
    chk(32'(overflow), 32'h0, "rst_overflow");

    // 2: ch0 free-run, hold, clear
    tick(1);
    wr(10'h000, 32'h1);
    chk_rd(10'h004, 32'h0, "ch0_start_e0");
    tick(10);
    chk_rd(10'h004, 32'hA, "ch0_after_10");
    tick(1);
    wr(10'h000, 32'h0);
    chk_rd(10'h004, 32'hC, "ch0_stop");
    tick(5);
    chk_rd(10'h004, 32'hC, "ch0_hold");
    wr(10'h000, 32'h3);
    chk_rd(10'h004, 32'hC, "ch0_clr_first_edge");
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk_rd(10'h004, 32'h0, "ch0_clr_value");
      chk(32'(overflow[0]), 32'h0, "ch0_clr_ovf");
    end
    wr(10'h000, 32'h0);

    // 3: ch1 up with LIMIT=4, sticky status and irq
    wr(10'h018, 32'h4);
    wr(10'h010, 32'h1);
    chk_rd(10'h014, 32'h0, "ch1_e0");
    chk(32'(overflow[1]), 32'h0, "ch1_ovf_e0");
    for (int k = 0; k < 6; k++) begin
      tick(1);
      chk_rd(10'h014, 32'(exp_up[k]), "ch1_value");
      chk(32'(overflow[1]), (exp_up[k] == 4) ? 32'h1 : 32'h0, "ch1_ovf");
    end
    chk_rd(10'h01C, HAS_IRQ ? 32'h1 : 32'h0, "ch1_status");
    wr(10'h010, 32'h0);
    wr(10'h100, 32'h2);
    chk_rd(10'h100, HAS_IRQ ? 32'h2 : 32'h0, "mask_rd");
    chk(32'(irq), 32'h0, "irq_not_yet");
    tick(1);
    chk(32'(irq), HAS_IRQ ? 32'h1 : 32'h0, "irq_set");
    wr(10'h01C, 32'h1);
    chk_rd(10'h01C, 32'h0, "ch1_w1c");
    chk(32'(irq), HAS_IRQ ? 32'h1 : 32'h0, "irq_hold_one_edge");
    tick(1);
    chk(32'(irq), 32'h0, "irq_clear");

    // 4: ch2 down with LIMIT=3
    wr(10'h028, 32'h3);
    wr(10'h020, 32'h5);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick(1);
      chk_rd(10'h024, 32'(exp_dn[k]), "ch2_value");
      chk(32'(overflow[2]), (exp_dn[k] == 0) ? 32'h1 : 32'h0, "ch2_ovf");
    end
    wr(10'h020, 32'h0);
    chk(32'(irq), 32'h0, "irq_masked_ch2");

    // 5: ch3 one-shot with LIMIT=2
    wr(10'h038, 32'h2);
    wr(10'h030, 32'h9);
    chk_rd(10'h034, 32'h0, "ch3_e0");
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk_rd(10'h034, 32'(exp_os[k]), "ch3_value");
    end
    tick(3);
    chk_rd(10'h034, 32'h0, "ch3_stopped");
    chk_rd(10'h030, 32'h8, "ch3_ctrl_cleared");
    chk(32'(overflow[3]), 32'h0, "ch3_ovf_stopped");
    // CPU write on the wrap edge overrides the hardware stop
    wr(10'h030, 32'h9);
    tick(2);
    chk_rd(10'h034, 32'h2, "ch3_rerun");
    wr(10'h030, 32'h9);
    chk_rd(10'h030, 32'h9, "ch3_ctrl_override");
    chk_rd(10'h034, 32'h0, "ch3_wrapped");
    tick(1);
    chk_rd(10'h034, 32'h1, "ch3_still_running");
    wr(10'h030, 32'h0);

    // 6: field masking, read-only and unmapped addresses
    wr(10'h000, 32'hFFFF_FFFF);
    chk_rd(10'h000, 32'hF, "ctrl_mask");
    wr(10'h014, 32'h55);
    chk_rd(10'h014, 32'h2, "value_ro");
    wr(10'h040, 32'h1);
    chk_rd(10'h040, 32'h0, "unmapped_040");
    chk_rd(10'h108, 32'h0, "unmapped_108");
    chk_rd(10'h3FC, 32'h0, "unmapped_3fc");
    chk_rd(10'h00C, 32'h0, "ch0_status");
    chk_rd(10'h02C, HAS_IRQ ? 32'h1 : 32'h0, "ch2_status");
    addr = 10'h018; rd_en = 1'b0;
    #1;
    chk(rdata, 32'h0, "rd_en_low");

    // Mid-operation reset
    wr(10'h000, 32'h1);
    tick(3);
    chk_rd(10'h004, 32'h3, "pre_reset_count");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_rd(10'h004, 32'h0, "mid_rst_value");
    chk_rd(10'h000, 32'h0, "mid_rst_ctrl");
    chk_rd(10'h018, 32'hFF, "mid_rst_limit");
    chk_rd(10'h02C, 32'h0, "mid_rst_status");
    chk(32'(irq), 32'h0, "mid_rst_irq");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
